// File: rtl/forwarding_register_file.sv
// forwarding_register_file: 2-read/1-write register file with write-through reads and a one-cycle write log.
// Entry 0 reads as zero and ignores writes; reset clears the array and the log asynchronously.
module forwarding_register_file #(
    parameter int                   DATA_SIZE     = 32,
    parameter int                   ADDRESS_SIZE  = 5,
    parameter logic [DATA_SIZE-1:0] INITIAL_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [ADDRESS_SIZE-1:0] write_address,
    input  logic [DATA_SIZE-1:0]    write_data,
    input  logic [31:0]             write_pc,
    input  logic [ADDRESS_SIZE-1:0] read_address_1,
    output logic [DATA_SIZE-1:0]    read_data_1,
    input  logic [ADDRESS_SIZE-1:0] read_address_2,
    output logic [DATA_SIZE-1:0]    read_data_2,
    output logic                    log_valid,
    output logic [ADDRESS_SIZE-1:0] log_address,
    output logic [DATA_SIZE-1:0]    log_data,
    output logic [31:0]             log_pc
);
    localparam int ENTRIES = 2 ** ADDRESS_SIZE;

    logic [ENTRIES-1:0][DATA_SIZE-1:0] r_regs;
    logic                              r_log_valid;
    logic [ADDRESS_SIZE-1:0]           r_log_address;
    logic [DATA_SIZE-1:0]              r_log_data;
    logic [31:0]                       r_log_pc;
    logic                              w_commit;
    logic                              w_fwd_1;
    logic                              w_fwd_2;

    // write_enable gates everything first so an undefined address while idle cannot reach the array
    assign w_commit = write_enable && (write_address != '0);
    assign w_fwd_1  = !reset && w_commit && (write_address == read_address_1);
    assign w_fwd_2  = !reset && w_commit && (write_address == read_address_2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regs        <= {ENTRIES{INITIAL_VALUE}};
            r_regs[0]     <= '0;
            r_log_valid   <= 1'b0;
            r_log_address <= '0;
            r_log_data    <= '0;
            r_log_pc      <= '0;
        end else begin
            r_log_valid <= w_commit;
            if (w_commit) begin
                r_regs[write_address] <= write_data;
                r_log_address         <= write_address;
                r_log_data            <= write_data;
                r_log_pc              <= write_pc;
            end
        end
    end

    always_comb begin
        read_data_1 = (read_address_1 == '0) ? '0 : w_fwd_1 ? write_data : r_regs[read_address_1];
        read_data_2 = (read_address_2 == '0) ? '0 : w_fwd_2 ? write_data : r_regs[read_address_2];
    end

    assign log_valid   = r_log_valid;
    assign log_address = r_log_address;
    assign log_data    = r_log_data;
    assign log_pc      = r_log_pc;
endmodule

// File: tb/tb_forwarding_register_file.sv
// tb_forwarding_register_file: directed table, corner sequences and random traffic against an array model.
module tb_forwarding_register_file;
    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [31:0] write_pc;
    logic [4:0]  read_address_1;
    logic [31:0] read_data_1;
    logic [4:0]  read_address_2;
    logic [31:0] read_data_2;
    logic        log_valid;
    logic [4:0]  log_address;
    logic [31:0] log_data;
    logic [31:0] log_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [32];
    logic        m_lv;
    logic [4:0]  m_la;
    logic [31:0] m_ld;
    logic [31:0] m_lp;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        elv;
    } vec_t;
    vec_t tbl [8];

    forwarding_register_file dut (
        .clk(clk), .reset(reset), .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .write_pc(write_pc), .read_address_1(read_address_1),
        .read_data_1(read_data_1), .read_address_2(read_address_2), .read_data_2(read_data_2),
        .log_valid(log_valid), .log_address(log_address), .log_data(log_data), .log_pc(log_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        m_lv = 1'b0;
        m_la = '0;
        m_ld = '0;
        m_lp = '0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 0) return 32'h0;
        if (write_enable && write_address == ra) return write_data;
        return mem[ra];
    endfunction

    task automatic edge_and_check_log();
        @(posedge clk);
        if (write_enable && write_address != 0) begin
            mem[write_address] = write_data;
            m_lv = 1'b1;
            m_la = write_address;
            m_ld = write_data;
            m_lp = write_pc;
        end else m_lv = 1'b0;
        #1;
        check("log_valid", {31'b0, log_valid}, {31'b0, m_lv});
        check("log_address", {27'b0, log_address}, {27'b0, m_la});
        check("log_data", log_data, m_ld);
        check("log_pc", log_pc, m_lp);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2);
        write_enable = we;
        write_address = wa;
        write_data = wd;
        write_pc = pc;
        read_address_1 = ra1;
        read_address_2 = ra2;
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 32'h3000, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b1};
        tbl[1] = '{1'b0, 5'd5, 32'h0, 32'h0, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0, 1'b0};
        tbl[2] = '{1'b1, 5'd0, 32'h12345678, 32'h3004, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 5'd9, 32'h1, 32'h3008, 5'd9, 5'd9, 32'h1, 32'h1, 1'b1};
        tbl[4] = '{1'b0, 5'd9, 32'h2, 32'h300C, 5'd9, 5'd9, 32'h1, 32'h1, 1'b0};
        tbl[5] = '{1'b1, 5'd9, 32'h2, 32'h3010, 5'd9, 5'd9, 32'h2, 32'h2, 1'b1};
        tbl[6] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd5, 32'h2, 32'hDEADBEEF, 1'b0};
        tbl[7] = '{1'b1, 5'd6, 32'h77, 32'h3014, 5'd6, 5'd9, 32'h77, 32'h2, 1'b1};

        // immediate asynchronous reset, before any clock edge
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0);
        model_reset();
        #1;
        check("reset_rd1", read_data_1, 32'h0);
        check("reset_log_valid", {31'b0, log_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].pc, tbl[i].ra1, tbl[i].ra2);
            #1;
            check($sformatf("tbl%0d_rd1", i), read_data_1, tbl[i].e1);
            check($sformatf("tbl%0d_rd2", i), read_data_2, tbl[i].e2);
            edge_and_check_log();
            check($sformatf("tbl%0d_lv", i), {31'b0, log_valid}, {31'b0, tbl[i].elv});
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        edge_and_check_log();
        check("log_valid_drops", {31'b0, log_valid}, 32'h0);

        // undefined address while idle must leave the array alone
        @(negedge clk);
        drive(1'b0, 5'bx, 32'hFFFF_FFFF, 32'h0, 5'd5, 5'd9);
        edge_and_check_log();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd9);
        #1;
        check("x_addr_e5", read_data_1, 32'hDEADBEEF);
        check("x_addr_e9", read_data_2, 32'h2);

        // reset raised 1 unit before the edge of a pending write
        drive(1'b1, 5'd3, 32'hAA, 32'h4000, 5'd3, 5'd6);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_pend_no_fwd", read_data_1, 32'h0);
        check("rst_pend_e6", read_data_2, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd6);
        #1;
        check("rst_pend_e3", read_data_1, 32'h0);
        check("rst_pend_lv", {31'b0, log_valid}, 32'h0);

        // back-to-back writes to every writable entry
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 32'(i * 3), 32'h5000 + 32'(i * 4), 5'(i), 5'(i - 1));
            #1;
            check("b2b_fwd", read_data_1, 32'(i * 3));
            check("b2b_prev", read_data_2, 32'((i - 1) * 3));
            edge_and_check_log();
            check("b2b_lv", {31'b0, log_valid}, 32'h1);
            check("b2b_la", {27'b0, log_address}, 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            check("b2b_rd1", read_data_1, 32'(i * 3));
            check("b2b_rd2", read_data_2, 32'((31 - i) * 3));
        end

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 5) == 0) read_address_1 = write_address;
            if ($urandom_range(0, 5) == 0) read_address_2 = write_address;
            #1;
            check("rnd_rd1", read_data_1, exp_rd(read_address_1));
            check("rnd_rd2", read_data_2, exp_rd(read_address_2));
            edge_and_check_log();
        end

        // asynchronous reset while the log is valid
        @(negedge clk);
        drive(1'b1, 5'd12, 32'hCAFE, 32'h6000, 5'd12, 5'd5);
        edge_and_check_log();
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd5);
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_lv", {31'b0, log_valid}, 32'h0);
        check("async_rst_e12", read_data_1, 32'h0);
        check("async_rst_lpc", log_pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
